// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: pad synchroniser, consecutive-sample glitch filter
// and one-cycle rise/fall/glitch pulses for the downstream GPIO core.
module gpio_in_filter #(
    parameter int                  GPIO_NUM    = 16,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_W       = 8,
    parameter logic [GPIO_NUM-1:0] RESET_VAL   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [GPIO_NUM-1:0] pin_i,
    input  logic [GPIO_NUM-1:0] filter_en_i,
    input  logic [CNT_W-1:0]    filter_cycles_i,
    output logic [GPIO_NUM-1:0] data_o,
    output logic [GPIO_NUM-1:0] rise_o,
    output logic [GPIO_NUM-1:0] fall_o,
    output logic [GPIO_NUM-1:0] glitch_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    logic [GPIO_NUM-1:0] sync_r [SYNC_STAGES];
    logic [GPIO_NUM-1:0] sample_s;
    state_e              state_r      [GPIO_NUM];
    state_e              state_nxt_s  [GPIO_NUM];
    logic [CNT_W-1:0]    cnt_r        [GPIO_NUM];
    logic [CNT_W-1:0]    cnt_nxt_s    [GPIO_NUM];
    logic [CNT_W:0]      cnt_inc_s    [GPIO_NUM];
    logic [GPIO_NUM-1:0] data_r;
    logic [GPIO_NUM-1:0] data_nxt_s;
    logic [GPIO_NUM-1:0] rise_r;
    logic [GPIO_NUM-1:0] fall_r;
    logic [GPIO_NUM-1:0] glitch_r;
    logic [GPIO_NUM-1:0] glitch_nxt_s;
    logic [CNT_W:0]      n_eff_s;

    assign sample_s = sync_r[SYNC_STAGES-1];
    // A zero threshold behaves like a threshold of one sample.
    assign n_eff_s  = (filter_cycles_i == {CNT_W{1'b0}}) ? (CNT_W+1)'(1)
                                                         : {1'b0, filter_cycles_i};

    // Pad synchroniser chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= pin_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Per-pin filter next-state logic; the increment is one bit wider so it never wraps.
    always_comb begin
        for (int p = 0; p < GPIO_NUM; p++) begin
            data_nxt_s[p]   = data_r[p];
            state_nxt_s[p]  = state_r[p];
            cnt_nxt_s[p]    = cnt_r[p];
            glitch_nxt_s[p] = 1'b0;
            cnt_inc_s[p]    = {1'b0, cnt_r[p]} + (CNT_W+1)'(1);
            if (!filter_en_i[p]) begin
                data_nxt_s[p]  = sample_s[p];
                cnt_nxt_s[p]   = {CNT_W{1'b0}};
                state_nxt_s[p] = ST_IDLE;
            end else begin
                case (state_r[p])
                    ST_IDLE: begin
                        if (sample_s[p] == data_r[p]) begin
                            state_nxt_s[p] = ST_IDLE;
                        end else if (n_eff_s == (CNT_W+1)'(1)) begin
                            data_nxt_s[p] = sample_s[p];
                        end else begin
                            cnt_nxt_s[p]   = CNT_W'(1);
                            state_nxt_s[p] = ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (sample_s[p] == data_r[p]) begin
                            cnt_nxt_s[p]    = {CNT_W{1'b0}};
                            glitch_nxt_s[p] = 1'b1;
                            state_nxt_s[p]  = ST_IDLE;
                        end else if (cnt_inc_s[p] >= n_eff_s) begin
                            data_nxt_s[p]  = sample_s[p];
                            cnt_nxt_s[p]   = {CNT_W{1'b0}};
                            state_nxt_s[p] = ST_IDLE;
                        end else begin
                            cnt_nxt_s[p] = cnt_inc_s[p][CNT_W-1:0];
                        end
                    end
                    default: begin
                        cnt_nxt_s[p]   = {CNT_W{1'b0}};
                        state_nxt_s[p] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Filter state and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < GPIO_NUM; p++) begin
                state_r[p] <= ST_IDLE;
                cnt_r[p]   <= {CNT_W{1'b0}};
            end
        end else begin
            for (int p = 0; p < GPIO_NUM; p++) begin
                state_r[p] <= state_nxt_s[p];
                cnt_r[p]   <= cnt_nxt_s[p];
            end
        end
    end

    // Filtered level and edge pulses, registered together so they stay aligned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r   <= RESET_VAL;
            rise_r   <= {GPIO_NUM{1'b0}};
            fall_r   <= {GPIO_NUM{1'b0}};
            glitch_r <= {GPIO_NUM{1'b0}};
        end else begin
            data_r   <= data_nxt_s;
            rise_r   <= data_nxt_s & ~data_r;
            fall_r   <= ~data_nxt_s & data_r;
            glitch_r <= glitch_nxt_s;
        end
    end

    assign data_o   = data_r;
    assign rise_o   = rise_r;
    assign fall_o   = fall_r;
    assign glitch_o = glitch_r;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a run-length reference model.
module tb_gpio_in_filter;

    localparam int NP = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] pin = '0;
    logic [NP-1:0] en = '0;
    logic [7:0]    ncyc = 8'd0;
    logic [NP-1:0] data_o, rise_o, fall_o, glitch_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    gpio_in_filter #(.GPIO_NUM(NP), .SYNC_STAGES(SS), .CNT_W(8), .RESET_VAL('0)) dut (
        .clk_i(clk), .rst_i(rst), .pin_i(pin), .filter_en_i(en),
        .filter_cycles_i(ncyc), .data_o(data_o), .rise_o(rise_o),
        .fall_o(fall_o), .glitch_o(glitch_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: pad value seen after SS edges; a pin's level follows it once it
    // has differed from the current level on neff consecutive filtered edges.
    logic [NP-1:0] dly_m [SS];
    logic [NP-1:0] d_m = '0, rise_m = '0, fall_m = '0, glitch_m = '0;
    int            run_m [NP];

    always @(posedge clk or posedge rst) begin
        logic [NP-1:0] nd, g, s;
        int neff;
        if (rst) begin
            for (int k = 0; k < SS; k++) dly_m[k] = '0;
            for (int i = 0; i < NP; i++) run_m[i] = 0;
            d_m = '0; rise_m = '0; fall_m = '0; glitch_m = '0;
        end else begin
            neff = (ncyc == 8'd0) ? 1 : int'(ncyc);
            s  = dly_m[SS-1];
            nd = d_m;
            g  = '0;
            for (int i = 0; i < NP; i++) begin
                if (!en[i]) begin
                    nd[i] = s[i];
                    run_m[i] = 0;
                end else if (s[i] != d_m[i]) begin
                    run_m[i]++;
                    if (run_m[i] >= neff) begin
                        nd[i] = s[i];
                        run_m[i] = 0;
                    end
                end else begin
                    g[i] = (run_m[i] > 0);
                    run_m[i] = 0;
                end
            end
            rise_m   = nd & ~d_m;
            fall_m   = ~nd & d_m;
            glitch_m = g;
            d_m      = nd;
            for (int k = SS - 1; k > 0; k--) dly_m[k] = dly_m[k-1];
            dly_m[0] = pin;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_o", data_o, d_m);
            chk("rise_o", rise_o, rise_m);
            chk("fall_o", fall_o, fall_m);
            chk("glitch_o", glitch_o, glitch_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; pin = '0; en = '0; ncyc = 8'd0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        apply_reset();
        chk("reset_data", data_o, 16'h0000);
        chk("reset_pulses", rise_o | fall_o | glitch_o, 16'h0000);

        // Bypass: level appears after edge 3.
        pin[0] = 1'b1;
        tick(); tick();
        chk("byp_e2_data", {15'd0, data_o[0]}, 16'h0000);
        tick();
        chk("byp_e3_data", {15'd0, data_o[0]}, 16'h0001);
        chk("byp_e3_rise", {15'd0, rise_o[0]}, 16'h0001);
        tick();
        chk("byp_e4_rise", {15'd0, rise_o[0]}, 16'h0000);

        // Filtered N=4: rises after edge 6, single rise pulse.
        apply_reset();
        en[3] = 1'b1; ncyc = 8'd4; pin[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("flt_data3", {15'd0, data_o[3]}, (k >= 6) ? 16'h0001 : 16'h0000);
            chk("flt_rise3", {15'd0, rise_o[3]}, (k == 6) ? 16'h0001 : 16'h0000);
        end

        // Three-sample pulse under N=4 is a glitch.
        apply_reset();
        en[5] = 1'b1; ncyc = 8'd4; pin[5] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) pin[5] = 1'b0;
            chk("gl_data5", {15'd0, data_o[5]}, 16'h0000);
            chk("gl_rise5", {15'd0, rise_o[5]}, 16'h0000);
            chk("gl_glitch5", {15'd0, glitch_o[5]}, (k == 6) ? 16'h0001 : 16'h0000);
        end

        // Threshold lowered mid-count: accept on the next edge.
        apply_reset();
        en[7] = 1'b1; ncyc = 8'd5; pin[7] = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        chk("thr_e5_data7", {15'd0, data_o[7]}, 16'h0000);
        ncyc = 8'd2;
        tick();
        chk("thr_e6_data7", {15'd0, data_o[7]}, 16'h0001);
        chk("thr_e6_rise7", {15'd0, rise_o[7]}, 16'h0001);

        // Reset asserted mid-count, then idle after release.
        apply_reset();
        en[2] = 1'b1; ncyc = 8'd8; pin[2] = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1; pin = '0;
        #1;
        chk("rstmid_data", data_o, 16'h0000);
        chk("rstmid_pulses", rise_o | fall_o | glitch_o, 16'h0000);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("post_rst_data", data_o, 16'h0000);
            chk("post_rst_pulses", rise_o | fall_o | glitch_o, 16'h0000);
        end

        // All pins toggle, mixed enables, N=3.
        apply_reset();
        en = 16'h00FF; ncyc = 8'd3; pin = 16'hFFFF;
        tick(); tick(); tick();
        chk("all_e3_data", data_o, 16'hFF00);
        chk("all_e3_rise", rise_o, 16'hFF00);
        tick();
        chk("all_e4_data", data_o, 16'hFF00);
        chk("all_e4_rise", rise_o, 16'h0000);
        tick();
        chk("all_e5_data", data_o, 16'hFFFF);
        chk("all_e5_rise", rise_o, 16'h00FF);

        // Maximum threshold: update after edge SS+255.
        apply_reset();
        en[0] = 1'b1; ncyc = 8'd255; pin[0] = 1'b1;
        for (int k = 1; k <= 259; k++) begin
            tick();
            if (k >= 255) begin
                chk("max_data0", {15'd0, data_o[0]}, (k >= 257) ? 16'h0001 : 16'h0000);
                chk("max_rise0", {15'd0, rise_o[0]}, (k == 257) ? 16'h0001 : 16'h0000);
            end
        end

        // Randomized traffic with occasional enable/threshold changes and resets.
        apply_reset();
        en = NP'($urandom);
        ncyc = 8'd3;
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(5) == 0) pin[i] = ~pin[i];
            end
            if ($urandom_range(39) == 0) en = NP'($urandom);
            if ($urandom_range(49) == 0) begin
                case ($urandom_range(5))
                    0: ncyc = 8'd0;
                    1: ncyc = 8'd1;
                    2: ncyc = 8'd2;
                    3: ncyc = 8'd4;
                    4: ncyc = 8'd6;
                    default: ncyc = 8'd3;
                endcase
            end
            rst = ($urandom_range(499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
